// File: rtl/lsu_ram_ctrl.sv
// lsu_ram_ctrl: load/store front-end for the word-wide data RAM.
// Turns RV32 byte/halfword/word accesses on byte addresses into word
// reads and writes. Sub-word stores are done as read-modify-write because
// the RAM has no byte enables. Loads are sign- or zero-extended on return.
// One request is outstanding at a time.
module lsu_ram_ctrl #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          ram_w_en,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_w_data,
    output logic          ram_r_en,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_r_data
);

    typedef enum logic [2:0] {
        IDLE,
        LD_WAIT,
        RMW_WAIT,
        RMW_WR,
        RSP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t          state;
    state_t          state_nxt;

    // Request fields captured on accept
    logic            cap_we;
    logic [1:0]      cap_size;
    logic            cap_unsigned;
    logic [1:0]      cap_off;
    logic [AW-1:0]   cap_waddr;
    logic [DW-1:0]   cap_wdata;

    // Merged word held between the RMW read and the RMW write
    logic [DW-1:0]   rmw_data;

    logic            accept;
    logic            misaligned;
    logic [AW-1:0]   req_waddr;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [DW-1:0]   ld_ext;
    logic [DW-1:0]   merged;

    // Address bits above the RAM, the store-flag copy and the upper store
    // data bits carry no information for this block.
    logic            unused_ok;
    assign unused_ok = ^{req_addr[31:AW+2], cap_we, cap_wdata[DW-1:16]};

    assign req_waddr = req_addr[AW+1:2];
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    // The response is suppressed during reset so an aborted op never completes.
    assign rsp_valid = (state == RSP) && !rst;

    // Alignment check on the incoming request
    always_comb begin
        misaligned = ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || (req_size == 2'd3);
    end

    // Load lane select and sign/zero extension from the RAM read word
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        ld_ext = ram_r_data;
        lane_b = ram_r_data[{cap_off, 3'b000} +: 8];
        lane_h = cap_off[1] ? ram_r_data[31:16] : ram_r_data[15:0];
        case (cap_size)
            SZ_BYTE: ld_ext = {{24{~cap_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: ld_ext = {{16{~cap_unsigned & lane_h[15]}}, lane_h};
            default: ld_ext = ram_r_data;
        endcase
    end

    // Sub-word store merge of captured data into the RAM read word
    always_comb begin
        merged = ram_r_data;
        if (cap_size == SZ_BYTE) begin
            merged[{cap_off, 3'b000} +: 8] = cap_wdata[7:0];
        end else begin
            merged[{cap_off[1], 4'b0000} +: 16] = cap_wdata[15:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and RAM port drive
    always_comb begin
        state_nxt  = state;
        ram_r_en   = 1'b0;
        ram_r_addr = req_waddr;
        ram_w_en   = 1'b0;
        ram_w_addr = req_waddr;
        ram_w_data = req_wdata;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        state_nxt = RSP;
                    end else if (!req_we) begin
                        ram_r_en  = 1'b1;
                        state_nxt = LD_WAIT;
                    end else if (req_size == SZ_WORD) begin
                        ram_w_en  = 1'b1;
                        state_nxt = RSP;
                    end else begin
                        ram_r_en  = 1'b1;
                        state_nxt = RMW_WAIT;
                    end
                end
            end
            LD_WAIT:  state_nxt = RSP;
            RMW_WAIT: state_nxt = RMW_WR;
            RMW_WR: begin
                // Reset in this cycle must cancel the write-back
                ram_w_en   = !rst;
                ram_w_addr = cap_waddr;
                ram_w_data = rmw_data;
                state_nxt  = RSP;
            end
            RSP:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request capture, RMW merge register and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we       <= 1'b0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_off      <= 2'd0;
            cap_waddr    <= '0;
            cap_wdata    <= '0;
            rmw_data     <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                cap_we       <= req_we;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_off      <= req_addr[1:0];
                cap_waddr    <= req_waddr;
                cap_wdata    <= req_wdata;
                // Errors and word stores respond next cycle
                if (misaligned) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b1;
                end else if (req_we && (req_size == SZ_WORD)) begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
            end
            case (state)
                LD_WAIT: begin
                    rsp_rdata <= ld_ext;
                    rsp_err   <= 1'b0;
                end
                RMW_WAIT: rmw_data <= merged;
                RMW_WR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed self-checking bench for lsu_ram_ctrl with a behavioural
// dual-port RAM (one-cycle read latency, same-address write forwarding).
module tb_lsu_ram_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_w_en;
    logic [AW-1:0] ram_w_addr;
    logic [31:0]   ram_w_data;
    logic          ram_r_en;
    logic [AW-1:0] ram_r_addr;
    logic [31:0]   ram_r_data;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    lsu_ram_ctrl #(.AW(AW), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_w_en     (ram_w_en),
        .ram_w_addr   (ram_w_addr),
        .ram_w_data   (ram_w_data),
        .ram_r_en     (ram_r_en),
        .ram_r_addr   (ram_r_addr),
        .ram_r_data   (ram_r_data)
    );

    always #5 clk = ~clk;

    // RAM model
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= (ram_w_en && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the next negedge, follow it until rsp_valid and
    // check response latency/data, write cycle/data/address and read count.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_reads, input int exp_wcyc, input logic [31:0] exp_wdata);
        int lat = -1;
        int wcyc = -1;
        int nrd = 0;
        logic [31:0] wdat = '0;
        logic [AW-1:0] waddr = '0;
        logic [AW-1:0] raddr = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        #1;
        check({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req_valid = 1'b0;
                #1;
            end
            if (ram_w_en) begin wcyc = c; wdat = ram_w_data; waddr = ram_w_addr; end
            if (ram_r_en) begin nrd++; raddr = ram_r_addr; end
            if (rsp_valid) begin lat = c; break; end
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/rdata"}, rsp_rdata, exp_rd);
        check({tag, "/err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        check({tag, "/reads"}, nrd, exp_reads);
        check({tag, "/wcycle"}, wcyc, exp_wcyc);
        if (exp_wcyc >= 0) begin
            check({tag, "/wdata"}, wdat, exp_wdata);
            check({tag, "/waddr"}, {20'b0, waddr}, {20'b0, addr[13:2]});
        end
        if (exp_reads > 0) check({tag, "/raddr"}, {20'b0, raddr}, {20'b0, addr[13:2]});
    endtask

    initial begin
        logic [7:0]  st_b [0:3];
        logic [31:0] ld_exp [0:3];
        int cyc, last_acc, k, n_ld, ld_idx;
        logic ld_out;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        ram_r_data = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst/ready", {31'b0, req_ready}, 32'd0);
        check("rst/rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst/rdata", rsp_rdata, 32'd0);
        check("rst/err", {31'b0, rsp_err}, 32'd0);
        check("rst/enables", {30'b0, ram_w_en, ram_r_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst/ready", {31'b0, req_ready}, 32'd1);

        // 1: word store then word load
        run_req("SW10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 0, 0, 32'hDEADBEEF);
        run_req("LW10", 0, 2'd2, 0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1, -1, 32'h0);

        // 2: sub-word loads with extension
        run_req("LB13", 0, 2'd0, 0, 32'h13, 32'h0, 2, 32'hFFFFFFDE, 0, 1, -1, 32'h0);
        run_req("LBU13", 0, 2'd0, 1, 32'h13, 32'h0, 2, 32'h000000DE, 0, 1, -1, 32'h0);
        run_req("LH10", 0, 2'd1, 0, 32'h10, 32'h0, 2, 32'hFFFFBEEF, 0, 1, -1, 32'h0);
        @(negedge clk);
        #1;
        check("hold/rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("hold/rdata", rsp_rdata, 32'hFFFFBEEF);
        run_req("LHU12", 0, 2'd1, 1, 32'h12, 32'h0, 2, 32'h0000DEAD, 0, 1, -1, 32'h0);

        // 3: read-modify-write stores
        run_req("SB11", 1, 2'd0, 0, 32'h11, 32'h55, 3, 32'h0, 0, 1, 2, 32'hDEAD55EF);
        run_req("SH12", 1, 2'd1, 0, 32'h12, 32'h1234, 3, 32'h0, 0, 1, 2, 32'h123455EF);
        run_req("LW10b", 0, 2'd2, 0, 32'h10, 32'h0, 2, 32'h123455EF, 0, 1, -1, 32'h0);

        // 4: misaligned and illegal size
        run_req("LW11", 0, 2'd2, 0, 32'h11, 32'h0, 1, 32'h0, 1, 0, -1, 32'h0);
        run_req("SH13", 1, 2'd1, 0, 32'h13, 32'hFFFF, 1, 32'h0, 1, 0, -1, 32'h0);
        run_req("SZ3", 0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, -1, 32'h0);

        // 5: reset while in RMW_WR
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hAA;
        #1;
        check("rstrmw/ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstrmw/no_write", {31'b0, ram_w_en}, 32'd0);
        check("rstrmw/no_rsp", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstrmw/ready_after", {31'b0, req_ready}, 32'd1);
        check("rstrmw/no_rsp_after", {31'b0, rsp_valid}, 32'd0);
        run_req("LW10c", 0, 2'd2, 0, 32'h10, 32'h0, 2, 32'h123455EF, 0, 1, -1, 32'h0);

        // 6: req_valid held high, alternating SB/LB to 0x21
        st_b[0] = 8'h83; st_b[1] = 8'h25; st_b[2] = 8'hF0; st_b[3] = 8'h7F;
        ld_exp[0] = 32'hFFFFFF83; ld_exp[1] = 32'h00000025;
        ld_exp[2] = 32'hFFFFFFF0; ld_exp[3] = 32'h0000007F;
        cyc = 0; last_acc = -1; k = 0; n_ld = 0; ld_idx = 0; ld_out = 1'b0;
        while (n_ld < 4 && cyc < 200) begin
            @(negedge clk);
            if (k < 8) begin
                req_valid = 1'b1; req_we = (k % 2 == 0); req_size = 2'd0;
                req_unsigned = 1'b0; req_addr = 32'h21;
                req_wdata = {24'h0, st_b[k / 2]};
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (rsp_valid && ld_out) begin
                check($sformatf("alt/ld%0d", ld_idx), rsp_rdata, ld_exp[ld_idx]);
                ld_out = 1'b0;
                n_ld++;
            end
            if (req_valid && req_ready) begin
                if (last_acc >= 0)
                    check($sformatf("alt/gap%0d", k), cyc - last_acc, (k % 2 == 1) ? 4 : 3);
                last_acc = cyc;
                if (k % 2 == 1) begin ld_out = 1'b1; ld_idx = k / 2; end
                k++;
            end
            cyc++;
        end
        req_valid = 1'b0;
        check("alt/loads_done", n_ld, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_ram_ctrl.md
Name: lsu_ram_ctrl

Overview:
- Load/store front-end placed directly upstream of the word-wide dual-port data RAM in the RISC core.
- Converts RV32 byte, halfword and word loads/stores on byte addresses into word-addressed RAM reads and writes.
- Sub-word stores use read-modify-write, because the RAM has no byte enables.
- Load data is sign- or zero-extended before being returned to the core. The RAM provides same-address write-to-read forwarding; this block does not.

Parameters:
AW, 12, RAM word-address width; bytes addressable = 4*2^AW
DW, 32, data width; only 32 is supported

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0])
rsp_valid  out  1  one-cycle pulse: request complete
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access or size = 3, qualified by rsp_valid
ram_w_en  out  1  RAM write enable
ram_w_addr  out  AW  RAM write word address
ram_w_data  out  32  RAM write data
ram_r_en  out  1  RAM read enable
ram_r_addr  out  AW  RAM read word address
ram_r_data  in  32  RAM read data, valid the cycle after ram_r_en

Behaviour:
- Word address = req_addr[AW+1:2]. Address bits above AW+1 are ignored. Byte offset = req_addr[1:0].
- Request is accepted on a cycle where req_valid && req_ready. On accept, req_we, req_size, req_unsigned, the offset, the word address and req_wdata are captured.
- req_ready = (state == IDLE) && !rst. There is no pipelining: one request is outstanding at a time.
- State machine: IDLE, LD_WAIT, RMW_WAIT, RMW_WR, RSP.
- Misaligned = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0) || size == 3.
  - Accept at T: no RAM access.
  - Go to RSP; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 at T+1.
- Load (accept at T):
  - ram_r_en = 1 and ram_r_addr = word address, combinationally in T.
  - IDLE -> LD_WAIT.
  - In T+1: select the byte or halfword at the offset, extend it, register it into rsp_rdata; LD_WAIT -> RSP.
  - rsp_valid = 1 at T+2.
- Word store (accept at T):
  - ram_w_en = 1, ram_w_addr = word address, ram_w_data = req_wdata, combinationally in T.
  - IDLE -> RSP; rsp_valid = 1 at T+1.
- Sub-word store (accept at T):
  - T: ram_r_en = 1 at the word address; IDLE -> RMW_WAIT.
  - T+1: merge ram_r_data with the captured data into the target lane(s); register the merged word; RMW_WAIT -> RMW_WR.
  - T+2: ram_w_en = 1 with the merged word; RMW_WR -> RSP.
  - rsp_valid = 1 at T+3.
- RSP: rsp_valid = 1 for exactly one cycle, then -> IDLE. req_ready returns high the cycle after rsp_valid.
- Outside active cycles, ram_w_en and ram_r_en are 0. Addresses and data are don't-care when their enable is 0 but must not be X.
- rsp_rdata and rsp_err hold their value until the next response. rsp_rdata = 0 for stores.
- Reset:
  - state = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; ram_w_en = 0; ram_r_en = 0; all captured registers = 0.
  - Reset mid-operation aborts the operation with no response. A partially completed RMW performs no write if reset occurs in RMW_WAIT or RMW_WR.
- Requests arriving while req_ready = 0 are ignored. The core must hold them until they are accepted.
- Back-to-back store then load to the same word is correct: the RMW write completes before the load read is issued.

Test Plan:
1. Reset, then word store addr 0x10, data 0xDEADBEEF -> ram_w_en at T, addr 4; rsp_valid at T+1, rsp_err = 0. Then load word 0x10 -> rsp_rdata = 0xDEADBEEF at T+2.
2. With word 4 = 0xDEADBEEF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
3. With word 4 = 0xDEADBEEF: SB 0x11, data 0x55 -> write 0xDEAD55EF at T+2, rsp_valid at T+3. Then SH 0x12, data 0x1234 -> word becomes 0x123455EF.
4. Misaligned LW 0x11, SH 0x13 and size = 3 -> no ram_w_en or ram_r_en; rsp_valid at T+1 with rsp_err = 1 and rsp_rdata = 0.
5. Assert rst in RMW_WR during SB 0x10, data 0xAA -> no RAM write, no rsp_valid, req_ready = 1 after reset; word 4 unchanged.
6. Hold req_valid high continuously with alternating SB/LB to the same address -> each request is accepted only in IDLE, and each load returns the previously stored byte.
